control_unit: RTL

- Instruction-sequencing controller for the 8-bit CPU.
- Consumes the 4-bit opcode (IRCU) from the instruction register and the answer-register zero flag.
- Drives every load, select and PC-source control of the datapath: ROM fetch, IR load, execute, PC update.
- Multi-cycle Moore FSM: 3 cycles per instruction, plus idle and halt states.

---
 rtl/control_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//   Instruction-sequencing controller for the 8-bit CPU. A Moore FSM walks
//   every instruction through FETCH -> LOAD_IR -> EXEC (three clocks). It
//   decodes the opcode in EXEC into the datapath load, select and PC-source
//   controls. HLT_OP parks the machine in HALT until Reset.
//
// Ports
//   Clk          system clock, rising edge
//   Reset        synchronous active-high reset (shared with datapath/PC/IR)
//   Start        level-sensitive run request, honoured only in IDLE
//   IRCU[3:0]    opcode field of the current instruction
//   Zero         answer register == 0 (value before the current instruction)
//   A_select     reg A source: 0 = InputA, 1 = answer
//   B_select     reg B source: 0 = InputB, 1 = answer
//   Aload/Bload  load reg A / reg B
//   ANSload      load answer register from ALU
//   select_mode  ALU op: 00 add, 01 sub, 10 and, 11 or
//   IRload       load IR from ROM output
//   PCload       load PC
//   JSM[1:0]     PC source: 00 PC+1, 01 IR address field, 10 mode input
//   Busy         high in FETCH, LOAD_IR and EXEC
//   Halted       high in HALT
//   InstrCount   retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module control_unit #(
  parameter int         CNT_W  = 8,
  parameter logic [3:0] HLT_OP = 4'hF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       IRCU,
  input  logic             Zero,
  output logic             A_select,
  output logic             B_select,
  output logic             Aload,
  output logic             Bload,
  output logic             ANSload,
  output logic [1:0]       select_mode,
  output logic             IRload,
  output logic             PCload,
  output logic [1:0]       JSM,
  output logic             Busy,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD_IR = 3'd2,
    EXEC    = 3'd3,
    HALT    = 3'd4
  } state_t;

  state_t state, state_nxt;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // One instruction retires on every EXEC cycle, including HLT.
  always_ff @(posedge Clk) begin
    if (Reset)              InstrCount <= '0;
    else if (state == EXEC) InstrCount <= InstrCount + 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (Start) state_nxt = FETCH;
      FETCH:   state_nxt = LOAD_IR;
      LOAD_IR: state_nxt = EXEC;
      EXEC:    state_nxt = (IRCU == HLT_OP) ? HALT : FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode (Moore on state, plus opcode/Zero while in EXEC)
  always_comb begin
    A_select    = 1'b0;
    B_select    = 1'b0;
    Aload       = 1'b0;
    Bload       = 1'b0;
    ANSload     = 1'b0;
    select_mode = 2'b00;
    IRload      = 1'b0;
    PCload      = 1'b0;
    JSM         = 2'b00;
    Busy        = (state == FETCH) || (state == LOAD_IR) || (state == EXEC);
    Halted      = (state == HALT);

    if (state == LOAD_IR) begin
      IRload = 1'b1;
    end else if (state == EXEC && IRCU != HLT_OP) begin
      // Checked first so HLT_OP wins even if parameterised onto a
      // regular opcode slot.
      PCload = 1'b1;
      unique case (IRCU)
        4'h1: Aload = 1'b1;
        4'h2: Bload = 1'b1;
        4'h3: begin A_select = 1'b1; Aload = 1'b1; end
        4'h4: begin B_select = 1'b1; Bload = 1'b1; end
        4'h5: ANSload = 1'b1;
        4'h6: begin ANSload = 1'b1; select_mode = 2'b01; end
        4'h7: begin ANSload = 1'b1; select_mode = 2'b10; end
        4'h8: begin ANSload = 1'b1; select_mode = 2'b11; end
        4'h9: JSM = 2'b01;
        4'hA: JSM = Zero ? 2'b01 : 2'b00;
        4'hB: JSM = 2'b10;
        default: ;  // NOP, reserved C/D/E
      endcase
    end
  end

endmodule
